// File: rtl/countdown_timer.sv
// MM:SS countdown timer: loadable BCD/mod-6 digits decremented by a tick strobe.
// Optional macro COUNTDOWN_AUTORELOAD_EN reloads the stored preset on expiry.
module countdown_timer (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       load,
    input  logic [2:0] ld_mt,
    input  logic [3:0] ld_mo,
    input  logic [2:0] ld_st,
    input  logic [3:0] ld_so,
    input  logic       start,
    input  logic       stop,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t     state_q, state_d;
    logic [2:0] mt_q, mt_d, st_q, st_d;
    logic [3:0] mo_q, mo_d, so_q, so_d;
    logic       running_q, running_d;
    logic       done_q, done_d;

    logic [2:0] cl_mt, cl_st;
    logic [3:0] cl_mo, cl_so;
    logic       nonzero, at_one;

    assign cl_mt = (ld_mt > 3'd5) ? 3'd5 : ld_mt;
    assign cl_st = (ld_st > 3'd5) ? 3'd5 : ld_st;
    assign cl_mo = (ld_mo > 4'd9) ? 4'd9 : ld_mo;
    assign cl_so = (ld_so > 4'd9) ? 4'd9 : ld_so;

    assign nonzero = (mt_q != 3'd0) || (mo_q != 4'd0) || (st_q != 3'd0) || (so_q != 4'd0);
    assign at_one  = (mt_q == 3'd0) && (mo_q == 4'd0) && (st_q == 3'd0) && (so_q == 4'd1);

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [2:0] pmt_q, pmt_d, pst_q, pst_d;
    logic [3:0] pmo_q, pmo_d, pso_q, pso_d;
    logic       preset_nz;

    assign preset_nz = (pmt_q != 3'd0) || (pmo_q != 4'd0) || (pst_q != 3'd0) || (pso_q != 4'd0);

    always_ff @(posedge clk) begin
        if (clr) begin
            pmt_q <= 3'd0;
            pmo_q <= 4'd0;
            pst_q <= 3'd0;
            pso_q <= 4'd0;
        end else begin
            pmt_q <= pmt_d;
            pmo_q <= pmo_d;
            pst_q <= pst_d;
            pso_q <= pso_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        pmt_d   = pmt_q;
        pmo_d   = pmo_q;
        pst_d   = pst_q;
        pso_d   = pso_q;
`endif
        if (load) begin
            mt_d    = cl_mt;
            mo_d    = cl_mo;
            st_d    = cl_st;
            so_d    = cl_so;
            state_d = IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
            pmt_d   = cl_mt;
            pmo_d   = cl_mo;
            pst_d   = cl_st;
            pso_d   = cl_so;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop && start && nonzero)
                        state_d = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (tick && at_one) begin
                        done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        if (preset_nz) begin
                            mt_d = pmt_q;
                            mo_d = pmo_q;
                            st_d = pst_q;
                            so_d = pso_q;
                        end else begin
                            so_d    = 4'd0;
                            state_d = EXPIRED;
                        end
`else
                        so_d    = 4'd0;
                        state_d = EXPIRED;
`endif
                    end else if (tick && nonzero) begin
                        // Borrow ripples left only while the lower digit is at zero.
                        so_d = (so_q == 4'd0) ? 4'd9 : so_q - 4'd1;
                        if (so_q == 4'd0) begin
                            st_d = (st_q == 3'd0) ? 3'd5 : st_q - 3'd1;
                            if (st_q == 3'd0) begin
                                mo_d = (mo_q == 4'd0) ? 4'd9 : mo_q - 4'd1;
                                if (mo_q == 4'd0)
                                    mt_d = mt_q - 3'd1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && start)
                        state_d = RUN;
                end
                default: state_d = EXPIRED;
            endcase
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            mt_q      <= 3'd0;
            mo_q      <= 4'd0;
            st_q      <= 3'd0;
            so_q      <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mt_q      <= mt_d;
            mo_q      <= mo_d;
            st_q      <= st_d;
            so_q      <= so_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
    assign running  = running_q;
    assign done     = done_q;

endmodule
